// File: rtl/data_mem_controller.sv
// data_mem_controller: round-robin arbiter sharing one data-memory port among NUM_CONSUMERS LSUs.
// Define DATA_MEM_CTRL_STATS_EN to add saturating read/write completion counters.
module data_mem_controller #(
    parameter int NUM_CONSUMERS = 8,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
    output logic mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic mem_write_ready
`ifdef DATA_MEM_CTRL_STATS_EN
    ,
    output logic [15:0] stat_reads,
    output logic [15:0] stat_writes
`endif
);
    localparam int IDX_BITS = $clog2(NUM_CONSUMERS);
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;
    state_t state;
    logic [IDX_BITS-1:0] rr_ptr, idx, pick, cand;
    logic found, pick_read;
    // First requester at or after rr_ptr wins; read beats write for the same requester.
    always_comb begin
        found = 1'b0;
        pick = '0;
        pick_read = 1'b0;
        cand = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand = IDX_BITS'((int'(rr_ptr) + k) % NUM_CONSUMERS);
            if (!found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
                found = 1'b1;
                pick = cand;
                pick_read = consumer_read_valid[cand];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            idx <= '0;
            consumer_read_ready <= '0;
            consumer_read_data <= '0;
            consumer_write_ready <= '0;
            mem_read_valid <= 1'b0;
            mem_read_address <= '0;
            mem_write_valid <= 1'b0;
            mem_write_address <= '0;
            mem_write_data <= '0;
`ifdef DATA_MEM_CTRL_STATS_EN
            stat_reads <= '0;
            stat_writes <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: if (found) begin
                    idx <= pick;
                    if (pick_read) begin
                        mem_read_valid <= 1'b1;
                        mem_read_address <= consumer_read_address[pick];
                        state <= READ_WAIT;
                    end else begin
                        mem_write_valid <= 1'b1;
                        mem_write_address <= consumer_write_address[pick];
                        mem_write_data <= consumer_write_data[pick];
                        state <= WRITE_WAIT;
                    end
                end
                READ_WAIT: if (mem_read_ready) begin
                    consumer_read_data[idx] <= mem_read_data;
                    consumer_read_ready[idx] <= 1'b1;
                    mem_read_valid <= 1'b0;
                    state <= RELAY;
`ifdef DATA_MEM_CTRL_STATS_EN
                    if (stat_reads != 16'hFFFF) stat_reads <= stat_reads + 16'd1;
`endif
                end
                WRITE_WAIT: if (mem_write_ready) begin
                    consumer_write_ready[idx] <= 1'b1;
                    mem_write_valid <= 1'b0;
                    state <= RELAY;
`ifdef DATA_MEM_CTRL_STATS_EN
                    if (stat_writes != 16'hFFFF) stat_writes <= stat_writes + 16'd1;
`endif
                end
                RELAY: if (consumer_read_ready[idx] ? !consumer_read_valid[idx] : !consumer_write_valid[idx]) begin
                    consumer_read_ready[idx] <= 1'b0;
                    consumer_write_ready[idx] <= 1'b0;
                    rr_ptr <= (idx == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0 : idx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: table-driven order checks, directed corner cases and random batches
// checked against a round-robin reference model with its own memory image.
module tb_data_mem_controller;
    localparam int N = 8;
    logic clk = 0;
    logic reset = 0;
    logic [N-1:0] rv = '0, wv = '0, crr, cwr;
    logic [N-1:0][7:0] ra = '0, wa = '0, wd = '0, crd;
    logic mrv, mwv, mrr = 0, mwr = 0;
    logic [7:0] mra, mwa, mwd, mrd = 0;
`ifdef DATA_MEM_CTRL_STATS_EN
    logic [15:0] sr, sw;
`endif
    int checks = 0, fails = 0;
    int mem_lat = 0;
    int model_ptr = 0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    typedef struct { int idx; bit wr; logic [7:0] addr; logic [7:0] data; } txn_t;
    txn_t obs[$], mlog[$], exp_q[$];
    typedef struct { logic [7:0] rm, wm; int lat; int n; logic [31:0] ord; } vec_t;
    vec_t vt[9];

    data_mem_controller dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(wv), .consumer_write_address(wa),
        .consumer_write_data(wd), .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr)
`ifdef DATA_MEM_CTRL_STATS_EN
        , .stat_reads(sr), .stat_writes(sw)
`endif
    );

    always #5 clk = ~clk;

    // Memory: answers after mem_lat extra cycles of valid, logs every completed handshake.
    initial begin
        int w = 0;
        forever begin
            @(negedge clk);
            mrr = 0;
            mwr = 0;
            if (!reset || !(mrv || mwv)) w = 0;
            else if (w < mem_lat) w++;
            else begin
                w = 0;
                if (mrv) begin
                    mrr = 1;
                    mrd = mem[mra];
                    mlog.push_back('{-1, 1'b0, mra, mem[mra]});
                end else begin
                    mwr = 1;
                    mem[mwa] = mwd;
                    mlog.push_back('{-1, 1'b1, mwa, mwd});
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 0;
        rv = '0;
        wv = '0;
        repeat (2) @(negedge clk);
        reset = 1;
        model_ptr = 0;
    endtask

    // Reference: serve pending requests one at a time in round-robin order from model_ptr.
    task automatic model(input logic [N-1:0] rm, input logic [N-1:0] wm);
        bit pr[N], pw[N];
        int left, c;
        exp_q.delete();
        left = $countones(rm) + $countones(wm);
        for (int i = 0; i < N; i++) begin
            pr[i] = rm[i];
            pw[i] = wm[i];
        end
        while (left > 0) begin
            for (int k = 0; k < N; k++) begin
                c = (model_ptr + k) % N;
                if (pr[c] || pw[c]) begin
                    if (pr[c]) begin
                        exp_q.push_back('{c, 1'b0, ra[c], ref_mem[ra[c]]});
                        pr[c] = 0;
                    end else begin
                        exp_q.push_back('{c, 1'b1, wa[c], wd[c]});
                        ref_mem[wa[c]] = wd[c];
                        pw[c] = 0;
                    end
                    model_ptr = (c + 1) % N;
                    left--;
                    break;
                end
            end
        end
    endtask

    task automatic run_batch(input logic [N-1:0] rm, input logic [N-1:0] wm, input int lat, input string tag);
        int cyc = 0;
        bit multi = 0;
        obs.delete();
        mlog.delete();
        mem_lat = lat;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            ra[i] = 8'($urandom);
            wa[i] = 8'($urandom);
            wd[i] = 8'($urandom);
        end
        model(rm, wm);
        rv = rm;
        wv = wm;
        while ((rv | wv) != 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if ($countones({crr, cwr}) > 1) multi = 1;
            for (int i = 0; i < N; i++) begin
                if (crr[i] && rv[i]) begin
                    obs.push_back('{i, 1'b0, ra[i], crd[i]});
                    rv[i] = 0;
                end
                if (cwr[i] && wv[i]) begin
                    obs.push_back('{i, 1'b1, wa[i], wd[i]});
                    wv[i] = 0;
                end
            end
        end
        check({tag, " finished"}, 32'(cyc < 500), 1);
        repeat (2) @(negedge clk);
        check({tag, " one ready"}, 32'(multi), 0);
        check({tag, " idle"}, {mrv, mwv, crr, cwr}, 0);
        check({tag, " count"}, obs.size(), exp_q.size());
        check({tag, " mem count"}, mlog.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < obs.size())
                check($sformatf("%s txn%0d", tag, k), {4'(obs[k].idx), 3'b0, obs[k].wr, obs[k].addr, obs[k].data},
                      {4'(exp_q[k].idx), 3'b0, exp_q[k].wr, exp_q[k].addr, exp_q[k].data});
            if (k < mlog.size())
                check($sformatf("%s mem%0d", tag, k), {mlog[k].wr, mlog[k].addr, mlog[k].data},
                      {exp_q[k].wr, exp_q[k].addr, exp_q[k].data});
        end
    endtask

    initial begin
        int cyc;
        bit saw3;
        logic [31:0] ord;
        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'(a * 37 + 11);
            ref_mem[a] = 8'(a * 37 + 11);
        end
        vt[0] = '{8'hFF, 8'h00, 0, 8, 32'h76543210};
        vt[1] = '{8'h04, 8'h00, 2, 1, 32'h2};
        vt[2] = '{8'h40, 8'h00, 1, 1, 32'h6};
        vt[3] = '{8'h82, 8'h00, 0, 2, 32'h17};
        vt[4] = '{8'h00, 8'h01, 1, 1, 32'h8};
        vt[5] = '{8'h10, 8'h10, 0, 2, 32'hC4};
        vt[6] = '{8'h21, 8'h21, 2, 4, 32'h8D05};
        vt[7] = '{8'h00, 8'hFF, 1, 8, 32'h8FEDCBA9};
        vt[8] = '{8'h0A, 8'h50, 0, 4, 32'hEC31};

        repeat (2) @(negedge clk);
        check("reset ctl", {mrv, mwv, crr, cwr}, 0);
        check("reset addr", {mra, mwa, mwd}, 0);
        check("reset rdata", 32'(crd == '0), 1);
        reset = 1;

        // Single read: consumer 2, address 0x10, data 0xAB after three cycles of valid.
        mem_lat = 2;
        mem[8'h10] = 8'hAB;
        ref_mem[8'h10] = 8'hAB;
        @(negedge clk);
        ra[2] = 8'h10;
        rv[2] = 1;
        @(negedge clk);
        check("rd valid", 32'(mrv), 1);
        check("rd addr", mra, 8'h10);
        for (cyc = 0; cyc < 20 && !crr[2]; cyc++) @(negedge clk);
        check("rd latency", cyc, 3);
        check("rd data", crd[2], 8'hAB);
        check("rd mem idle", 32'(mrv), 0);
        repeat (2) @(negedge clk);
        check("rd ready held", crr, 8'h04);
        rv[2] = 0;
        @(negedge clk);
        check("rd ready drop", crr, 0);
        model_ptr = 3;
        run_batch(8'h0C, 8'h00, 0, "ptr3");
        check("ptr3 first", obs.size() > 0 ? obs[0].idx : -1, 3);

        // Single write: consumer 0 writes 0x55 to 0x20.
        mem_lat = 2;
        @(negedge clk);
        wa[0] = 8'h20;
        wd[0] = 8'h55;
        wv[0] = 1;
        @(negedge clk);
        check("wr req", {mwv, mwa, mwd}, {1'b1, 8'h20, 8'h55});
        @(negedge clk);
        check("wr hold", {mwv, mwa, mwd}, {1'b1, 8'h20, 8'h55});
        for (cyc = 0; cyc < 20 && !cwr[0]; cyc++) @(negedge clk);
        check("wr ready", {cwr, mwv}, {8'h01, 1'b0});
        wv[0] = 0;
        ref_mem[8'h20] = 8'h55;
        @(negedge clk);
        check("wr ready drop", cwr, 0);
        model_ptr = 1;

        // Reset during READ_WAIT abandons the read; consumer 5 is then served normally.
        mem_lat = 6;
        @(negedge clk);
        ra[3] = 8'h33;
        rv[3] = 1;
        repeat (3) @(negedge clk);
        check("mid read busy", 32'(mrv), 1);
        reset = 0;
        @(negedge clk);
        check("mid rst ctl", {mrv, mwv, crr, cwr}, 0);
        check("mid rst addr", {mra, mwa, mwd}, 0);
        check("mid rst rdata", 32'(crd == '0), 1);
        reset = 1;
        rv[3] = 0;
        mem_lat = 0;
        ra[5] = 8'h55;
        rv[5] = 1;
        saw3 = 0;
        @(negedge clk);
        check("post rst addr", {mrv, mra}, {1'b1, 8'h55});
        for (cyc = 0; cyc < 20 && !crr[5]; cyc++) begin
            if (crr[3]) saw3 = 1;
            @(negedge clk);
        end
        check("post rst ready", crr, 8'h20);
        check("post rst data", crd[5], ref_mem[8'h55]);
        check("abandoned no ready", 32'(saw3), 0);
        rv[5] = 0;
        repeat (2) @(negedge clk);

        do_reset();
        for (int v = 0; v < 9; v++) begin
            run_batch(vt[v].rm, vt[v].wm, vt[v].lat, $sformatf("vec%0d", v));
            check($sformatf("vec%0d n", v), obs.size(), vt[v].n);
            ord = vt[v].ord;
            for (int k = 0; k < vt[v].n && k < obs.size(); k++)
                check($sformatf("vec%0d order%0d", v, k), {obs[k].wr, 3'(obs[k].idx)}, ord[4*k +: 4]);
        end

        for (int r = 0; r < 30; r++)
            run_batch(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Round-robin arbiter and sequencer that shares one data-memory port among NUM_CONSUMERS LSU requesters.
- Requesters are the per-thread load/store units of all compute cores, flattened.
- Sits between the compute cores and the external data memory.
- Relays each read or write request over the valid/ready handshake and returns read data to the granted requester only.

Parameters:
- NUM_CONSUMERS, 8, number of LSU requesters (>=2).
- ADDR_BITS, 8, data memory address width.
- DATA_BITS, 8, data memory data width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- consumer_read_valid  input  [NUM_CONSUMERS]  per-requester read request.
- consumer_read_address  input  [NUM_CONSUMERS][ADDR_BITS]  read addresses.
- consumer_read_ready  output  [NUM_CONSUMERS]  read complete.
- consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  returned read data.
- consumer_write_valid  input  [NUM_CONSUMERS]  per-requester write request.
- consumer_write_address  input  [NUM_CONSUMERS][ADDR_BITS]  write addresses.
- consumer_write_data  input  [NUM_CONSUMERS][DATA_BITS]  write data.
- consumer_write_ready  output  [NUM_CONSUMERS]  write complete.
- mem_read_valid  output  1  memory read request.
- mem_read_address  output  ADDR_BITS  memory read address.
- mem_read_ready  input  1  memory read data valid.
- mem_read_data  input  DATA_BITS  memory read data.
- mem_write_valid  output  1  memory write request.
- mem_write_address  output  ADDR_BITS  memory write address.
- mem_write_data  output  DATA_BITS  memory write data.
- mem_write_ready  input  1  memory write accepted.

Behaviour:
- Reset (reset==0 at clk edge):
  - State IDLE; rr_ptr=0.
  - All outputs 0, including consumer_read_data.
  - Any in-flight transaction is abandoned; no ready is issued for it.
- States: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE arbitration:
  - Scan consumers rr_ptr, rr_ptr+1, … modulo NUM_CONSUMERS.
  - First consumer with read_valid|write_valid wins; read has priority if both are set.
  - Latch grant index and address (plus write data for writes).
  - Next state READ_WAIT or WRITE_WAIT.
  - mem_*_valid asserts the cycle after the request is first seen in IDLE (1-cycle grant latency).
- READ_WAIT:
  - Hold mem_read_valid=1 and the latched address until mem_read_ready==1 is sampled.
  - On that edge: consumer_read_data[idx]<=mem_read_data; consumer_read_ready[idx]<=1; mem_read_valid<=0; go RELAY.
- WRITE_WAIT:
  - Hold mem_write_valid, address and data until mem_write_ready==1.
  - Then consumer_write_ready[idx]<=1; mem_write_valid<=0; go RELAY.
- RELAY:
  - Hold the consumer ready until the granted consumer's corresponding valid is sampled 0.
  - Then deassert ready; rr_ptr<=idx+1, wrapping NUM_CONSUMERS-1 -> 0; go IDLE.
- Handshake rules:
  - Requester holds valid and address stable until it sees ready.
  - At most one consumer ready bit is high at any time.
  - Exactly one memory transaction is outstanding at a time.
- consumer_read_data[i] holds its last value until the next read granted to i.
- Changes to non-granted requests during a transaction are ignored until the return to IDLE.
- Minimum transaction time: 1 cycle IDLE + ≥1 cycle WAIT + ≥1 cycle RELAY.
- No requests: stay in IDLE with all valids low.

Optional Feature:
- Macro DATA_MEM_CTRL_STATS_EN.
- Defined:
  - Adds outputs stat_reads[15:0] and stat_writes[15:0].
  - Each increments on completion of a read/write memory handshake (mem_*_ready sampled in a WAIT state).
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single read: consumer 2 reads addr 0x10, mem returns 0xAB after 3 cycles -> mem_read_address=0x10; consumer_read_data[2]=0xAB; consumer_read_ready[2] high until valid drops; rr_ptr=3.
- Single write: consumer 0 writes 0x55 to 0x20 -> mem_write_valid with addr 0x20, data 0x55 held until mem_write_ready; then consumer_write_ready[0] pulses.
- Fairness: all 8 consumers request reads simultaneously, with memory ready 1 cycle after valid each time -> grants 0,1,…,7 in order; no requester granted twice.
- Wrap-around: rr_ptr=7, consumers 7 and 1 request -> 7 served first, then 1.
- Read+write same consumer: consumer 4 asserts both -> read performed first, write on a later grant.
- Reset mid-read: assert reset low during READ_WAIT -> next edge all outputs 0, state IDLE; subsequent request from consumer 5 served normally.
